// File: rtl/wb_pkg.sv
// Shared write-back types: default register widths and the holding-buffer entry layout.
package wb_pkg;
  localparam int WB_WIDTH = 32;
  localparam int WB_AW    = 5;

  typedef struct packed {
    logic                valid;
    logic [WB_AW-1:0]    rd;
    logic [WB_WIDTH-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// ALU holding buffer: push at tail, pop at head, invalidate-by-rd; entries read out oldest-first.
// Pointers wrap modulo DEPTH; killed entries keep their slot until popped, so cnt still counts them.
module wb_fifo import wb_pkg::*; #(
  parameter int WIDTH = WB_WIDTH,
  parameter int AW    = WB_AW,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [AW-1:0]    push_rd,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             kill,
  input  logic [AW-1:0]    kill_rd,
  output logic [CW-1:0]    cnt,
  output wb_entry_t        ent_ord [DEPTH]
);
  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && mem[i].valid && mem[i].rd == WB_AW'(kill_rd)) mem[i].valid <= 1'b0;
      end
      if (push) begin
        mem[wr_ptr] <= '{valid: 1'b1, rd: WB_AW'(push_rd), data: WB_WIDTH'(push_data)};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        mem[rd_ptr].valid <= 1'b0;
        rd_ptr            <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Age-ordered view (index 0 = head); slots beyond cnt read as invalid.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_ord[i] = mem[rd_ptr + PW'(i)];
      if (CW'(i) >= cnt) ent_ord[i].valid = 1'b0;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: loads win, ALU results buffered behind them; 1-cycle registered write.
// alu_ready drops when the buffer is full; optional pending-write lookup built only with WB_BYPASS_EN.
module wb_arbiter import wb_pkg::*; #(
  parameter int WIDTH = WB_WIDTH,
  parameter int AW    = WB_AW,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [AW-1:0]    alu_rd,
  input  logic [WIDTH-1:0] alu_data,
  output logic             alu_ready,
  input  logic             mem_valid,
  input  logic [AW-1:0]    mem_rd,
  input  logic [WIDTH-1:0] mem_data,
  output logic             we,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_din,
  input  logic [AW-1:0]    byp_addr,
  output logic             byp_hit,
  output logic [WIDTH-1:0] byp_data,
  output logic [CW-1:0]    pend_cnt
);
  wb_entry_t        ent_ord [DEPTH];
  logic             alu_acc;
  logic             push;
  logic             pop;
  logic             kill;
  logic             nxt_we;
  logic [AW-1:0]    nxt_addr;
  logic [WIDTH-1:0] nxt_din;

  assign alu_ready = (pend_cnt < CW'(DEPTH));
  assign alu_acc   = alu_valid && alu_ready;

  wb_fifo #(.WIDTH(WIDTH), .AW(AW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_rd   (alu_rd),
    .push_data (alu_data),
    .pop       (pop),
    .kill      (kill),
    .kill_rd   (mem_rd),
    .cnt       (pend_cnt),
    .ent_ord   (ent_ord)
  );

  // rd=0 results are consumed but never written or buffered.
  always_comb begin
    nxt_we   = 1'b0;
    nxt_addr = wr_addr;
    nxt_din  = wr_din;
    push     = 1'b0;
    pop      = 1'b0;
    kill     = 1'b0;
    if (mem_valid) begin
      kill = (mem_rd != '0);
      push = alu_acc && (alu_rd != '0);
      if (mem_rd != '0) begin
        nxt_we   = 1'b1;
        nxt_addr = mem_rd;
        nxt_din  = mem_data;
      end
    end else if (pend_cnt != '0) begin
      pop  = 1'b1;
      push = alu_acc && (alu_rd != '0);
      if (ent_ord[0].valid) begin
        nxt_we   = 1'b1;
        nxt_addr = ent_ord[0].rd[AW-1:0];
        nxt_din  = ent_ord[0].data[WIDTH-1:0];
      end
    end else if (alu_acc && (alu_rd != '0)) begin
      nxt_we   = 1'b1;
      nxt_addr = alu_rd;
      nxt_din  = alu_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we      <= 1'b0;
      wr_addr <= '0;
      wr_din  <= '0;
    end else begin
      we      <= nxt_we;
      wr_addr <= nxt_addr;
      wr_din  <= nxt_din;
    end
  end

`ifdef WB_BYPASS_EN
  // Youngest buffered match overrides the output register, which is older.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    if (byp_addr != '0) begin
      if (we && wr_addr == byp_addr) begin
        byp_hit  = 1'b1;
        byp_data = wr_din;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_ord[i].valid && ent_ord[i].rd[AW-1:0] == byp_addr) begin
          byp_hit  = 1'b1;
          byp_data = ent_ord[i].data[WIDTH-1:0];
        end
      end
    end
  end
`else
  logic unused_byp;
  assign byp_hit  = 1'b0;
  assign byp_data = '0;
  always_comb begin
    unused_byp = ^byp_addr;
    for (int i = 0; i < DEPTH; i++) unused_byp = unused_byp ^ (^ent_ord[i]);
  end
`endif
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of one register.
REQ-002 SHALL have parameter AW, default 5, register address width.
REQ-003 SHALL have parameter DEPTH, default 4, ALU holding-buffer entries (power of two, >=2).
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports alu_valid / alu_rd / alu_data, inputs, 1 / AW / WIDTH, ALU result offer.
REQ-007 SHALL have port alu_ready, output, 1, ALU result accepted when alu_valid&&alu_ready.
REQ-008 SHALL have ports mem_valid / mem_rd / mem_data, inputs, 1 / AW / WIDTH, load result, never stalled.
REQ-009 SHALL have ports we / wr_addr / wr_din, outputs, 1 / AW / WIDTH, register-file write port drive.
REQ-010 SHALL have ports byp_addr (input, AW), byp_hit (output, 1), byp_data (output, WIDTH), pending-write lookup.
REQ-011 SHALL have port pend_cnt, output, $clog2(DEPTH)+1, buffered ALU entries.

Function
REQ-012 SHALL register we/wr_addr/wr_din on posedge clk; latency from accepted input to we asserted is 1 cycle; register file commits on the following negedge.
REQ-013 SHALL give mem_valid absolute priority: mem write always issued next cycle.
REQ-014 SHALL issue an ALU result directly (bypassing the buffer) when buffer empty and mem_valid=0.
REQ-015 SHALL push accepted ALU results into the FIFO buffer when mem_valid=1 or buffer non-empty; drain oldest entry on each cycle with mem_valid=0.
REQ-016 SHALL hold alu_ready = (pend_cnt < DEPTH); push and pop in the same cycle permitted when full (alu_ready stays 0 when full regardless).
REQ-017 SHALL never assert we for rd=0; such mem or ALU results are consumed and dropped (no buffer entry, no write).
REQ-018 SHALL, when mem_valid with mem_rd!=0, invalidate every buffered entry with matching rd in the same cycle; invalidated entries pop without asserting we.
REQ-019 SHALL drive we=0 on any cycle with nothing to issue; wr_addr/wr_din hold last value.
REQ-020 SHALL compute byp_hit/byp_data combinationally: youngest valid buffer entry with rd==byp_addr, else output register if we && wr_addr==byp_addr; byp_addr=0 always misses.
REQ-021 SHALL drive byp_data=0 when byp_hit=0.
REQ-022 SHALL wrap FIFO pointers modulo DEPTH; pend_cnt counts valid and invalidated-but-unpopped entries.

Reset
REQ-023 SHALL on rst=0 immediately clear we, wr_addr, wr_din, pointers, pend_cnt and all entry valid bits; alu_ready=1 after reset.
REQ-024 SHALL drop all pending writes when reset asserts mid-operation; none issued after release.
REQ-025 SHALL accept inputs on first posedge after rst deasserts.

Configuration
REQ-026 SHALL compile lookup logic only when WB_BYPASS_EN is defined; otherwise byp_hit=0, byp_data=0, byp_addr ignored, all other behaviour identical.

Structure
REQ-027 SHALL take WIDTH/AW defaults and a buffer-entry typedef (valid, rd, data) from shared package wb_pkg.
REQ-028 SHALL implement the buffer in sub-module wb_fifo (push, pop, kill-by-rd, per-entry read-out for lookup).

Verification
REQ-029 SHALL cover: alu_valid, rd=3, data=0x11, buffer empty -> next cycle we=1, wr_addr=3, wr_din=0x11.
REQ-030 SHALL cover: mem rd=5 data=0xA and alu rd=6 data=0xB same cycle -> cycle+1 writes x5=0xA, cycle+2 writes x6=0xB.
REQ-031 SHALL cover: ALU x7=0x1 buffered, then mem x7=0x2 -> only x7=0x2 written; buffered entry popped with we=0.
REQ-032 SHALL cover: mem_valid held 5 cycles with ALU pushes every cycle, DEPTH=4 -> alu_ready=0 after 4th push, pend_cnt=4, drains in order afterward.
REQ-033 SHALL cover: WB_BYPASS_EN defined, buffered x9=0x33 and x9=0x44 -> byp_addr=9 gives hit=1, data=0x44; byp_addr=0 gives hit=0.
REQ-034 SHALL cover: rst pulsed low with 3 entries pending -> we=0, pend_cnt=0 immediately; no writes after release.
